// File: rtl/sram_like_slave.sv
// sram_like_slave: SRAM-like bus target. It accepts req/addr_ok handshakes,
// performs each access against an internal word array, and answers every
// request in order with a single data_ok pulse. The pulse comes at least
// LATENCY cycles after acceptance, and up to QDEPTH requests can be outstanding.
module sram_like_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         PW    = $clog2(QDEPTH);
  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(LATENCY);
  localparam logic [PW:0] QFULL = (PW + 1)'(QDEPTH);
  localparam logic [PW:0] ONE   = (PW + 1)'(1);

  // Word array; never reset, so accepted writes survive a reset.
  logic [31:0] mem [DEPTH];

  // Response queue: one data word and one age counter per entry.
  logic [31:0] q_data [QDEPTH];
  logic [3:0]  q_age  [QDEPTH];

  logic [PW:0]           head;
  logic [PW:0]           tail;
  logic [PW:0]           count;
  logic [PW-1:0]         head_idx;
  logic [PW-1:0]         tail_idx;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic [31:0]           rd_word;
  logic [31:0]           push_data;
  logic                  unused_bits;

  // Byte offset, high alias bits and the size hint play no part in the access.
  assign unused_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0], size};

  assign widx     = addr[ADDR_WIDTH+1:2];
  assign head_idx = head[PW-1:0];
  assign tail_idx = tail[PW-1:0];

  // addr_ok depends only on registered state and stall, never on req or on this cycle's pop.
  assign addr_ok    = !reset && !stall && (count < QFULL);
  assign push       = req && addr_ok;
  assign head_valid = (count != '0);
  assign data_ok    = head_valid && (q_age[head_idx] >= LAT);
  assign pop        = data_ok;
  assign rdata      = data_ok ? q_data[head_idx] : '0;

  // A read captures the word as it stands before this edge; writes respond with zero.
  assign rd_word   = mem[widx];
  assign push_data = wr ? '0 : rd_word;

  // Byte-enabled write into the array on an accepted write.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Capture the response word into the tail slot; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail_idx] <= push_data;
    end
  end

  // Age every slot each cycle, saturating at LATENCY; a new entry starts at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && (tail_idx == PW'(i))) begin
          q_age[i] <= 4'd1;
        end else if (q_age[i] < LAT) begin
          q_age[i] <= q_age[i] + 4'd1;
        end
      end
    end
  end

  // Queue pointers and occupancy; reset drops every outstanding response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + ONE;
      end
      if (pop) begin
        head <= head + ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/sram_like_slave.md
# sram_like_slave

Memory responder for the CPU's SRAM-like bus: the target end that the instruction or data port of `mycpu_top` talks to in the bench and FPGA wrapper once the core moves from the fixed-latency SRAM port to the req/addr_ok/data_ok handshake. It accepts requests through `req`/`addr_ok` and performs the access against an internal word array. It then returns one `data_ok` pulse per request, in order, after a programmable latency, with up to `QDEPTH` requests outstanding. The `stall` input lets the bench throttle address acceptance to exercise CPU backpressure paths.

## Interface
- `ADDR_WIDTH`, 10: word-index width; the array holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: minimum cycles from acceptance to `data_ok`; legal range 1..15.
- `QDEPTH`, 4: maximum outstanding requests; power of two, legal range 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid.
- `wr`  in  1  1 = write, 0 = read.
- `size`  in  2  0 = byte, 1 = half, 2 = word; informational only, `wstrb` governs writes.
- `addr`  in  32  byte address; word index = `addr[ADDR_WIDTH+1:2]`.
- `wstrb`  in  4  byte enables for writes.
- `wdata`  in  32  write data.
- `stall`  in  1  forces `addr_ok` low while high.
- `addr_ok`  out  1  request accepted this cycle when `req && addr_ok`.
- `data_ok`  out  1  response valid for the oldest outstanding request; single-cycle pulse, no backpressure.
- `rdata`  out  32  read data, valid with `data_ok`.

## Operation
- Response queue: circular, `QDEPTH` entries. Each entry holds the data word and an age counter.
- State: head pointer, tail pointer, and count, each log2(QDEPTH)+1 bits wide.
- `addr_ok` = `!reset && !stall && count < QDEPTH`. It is combinational from registered state plus `stall`, and never depends on `req` or on the current cycle's pop.
- Acceptance is `req && addr_ok`.
  - Write: each byte `i` with `wstrb[i]=1` is updated in the array at the clock edge. Enqueue data = 0.
  - Read: enqueue the array word at the word index. The read returns the array state before any write at the same edge, which is never simultaneous because only one request is accepted per cycle.
- Ordering: a read accepted after a write to the same word returns the written data.
- Address aliasing: `addr[31:ADDR_WIDTH+2]` and `addr[1:0]` are ignored. There is no misalignment check.
- Age: a new entry starts at age 1. Every entry's age increments each cycle, saturating at `LATENCY`.
- Response: `data_ok` = head valid `&& head age >= LATENCY`. `rdata` = head data when `data_ok` is high, otherwise 0.
- Pop: when `data_ok` is high, the head advances at the edge. Push and pop in the same cycle leave `count` unchanged.
- Array contents are not cleared by reset. Simulation initial contents are all zero.

## Timing
- Reset: `count`, pointers, and ages are cleared immediately.
  - Reset values: `data_ok`=0, `rdata`=0, `addr_ok`=0 while `reset` is high.
  - After release: `addr_ok`=`!stall` in the first cycle.
- Reset mid-operation: all outstanding responses are discarded and no `data_ok` follows them. Writes already accepted remain in the array.
- A request accepted in cycle T produces `data_ok` in cycle T+`LATENCY` if every older request has already been answered. Otherwise it is answered in the cycle after the previous `data_ok`, at the earliest.
- Throughput is at most one acceptance and one response per cycle. Sustained one-per-cycle operation requires `QDEPTH > LATENCY`.
- Full: when `count == QDEPTH`, `addr_ok` is 0 in that cycle even if `data_ok` is 1. `addr_ok` reasserts in the cycle after the pop.
- `stall` and `req` changes affect only the current cycle's `addr_ok`. The core must hold `req`, `addr`, and the other request fields until it sees `addr_ok`.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `addr_ok`, `data_ok`, and `rdata` are 0 immediately. After release with `stall=0`, `addr_ok`=1 in the first cycle.
- Write then read, `LATENCY`=2:
  - Write 0x12345678 to 0x40 with `wstrb`=4'hF in cycle 0 → `data_ok`=1 and `rdata`=0 in cycle 2.
  - Read 0x40 in cycle 1 → `data_ok`=1 and `rdata`=0x12345678 in cycle 3.
- Byte strobes: word 0x80 holds 0xAABBCCDD; write 0x11223344 with `wstrb`=4'b0101, then read → 0xAA22CC44.
- Back-to-back: with `LATENCY`=2 and `QDEPTH`=4, accept 6 reads in cycles 0–5 → `data_ok` in cycles 2–7, in order, and `addr_ok` never drops.
- Full queue: with `LATENCY`=8 and `QDEPTH`=4, hold `req`=1 → 4 acceptances in cycles 0–3, `addr_ok`=0 in cycles 4–8, first `data_ok` in cycle 8, next acceptance in cycle 9.
- Stall, alias, and reset:
  - `stall`=1 for 3 cycles with `req` held → no acceptance until `stall` drops.
  - Read of `addr` = 0x1000 | 0x40 with `ADDR_WIDTH`=10 → returns the word at 0x40.
  - Reset with 3 requests outstanding → none of them produces `data_ok`.
